// File: rtl/iq_capture_pkg.sv
// Shared types and constants for the IQ capture sequencer: FSM state encoding,
// default widths and the system-bus offsets of its control/status registers.
package iq_capture_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [15:0] CTRL_ARM_OFFSET        = 16'h007C;
    localparam logic [15:0] STATUS_OFFSET          = 16'h307C;
    localparam logic [15:0] TRIG_START_ADDR_OFFSET = 16'h3080;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } capture_state_t;

    function automatic logic is_busy(input capture_state_t s);
        return (s == PRE) || (s == ARMED) || (s == POST);
    endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Decimation strobe: fires when the counter is 0 and the counter runs 0..decim.
// clear restarts the count at 0 and loads the decimation value for this run.
module sample_strobe_gen #(
    parameter int DECIM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               strobe
);

    logic [DECIM_W-1:0] count;
    logic [DECIM_W-1:0] decim;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            decim <= '0;
        end else if (clear) begin
            count <= '0;
            decim <= decim_i;
        end else if (count == decim) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign strobe = (count == '0);

endmodule

// File: rtl/iq_capture_sequencer.sv
// Triggered acquisition controller for the IQ capture RAM: circular pre-trigger
// fill, trigger capture, post-trigger fill, and oldest/trigger address readback.
module iq_capture_sequencer
    import iq_capture_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DECIM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               sw_trig_i,
    input  logic               trig_i,
    input  logic               trig_ext_en_i,
    input  logic [ADDR_W-1:0]  pretrig_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic               ram_wren_o,
    output logic [DATA_W-1:0]  ram_wdata_o,
    output logic               busy_o,
    output logic               armed_o,
    output logic               done_o,
    output logic [ADDR_W-1:0]  trig_addr_o,
    output logic [ADDR_W-1:0]  start_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    capture_state_t    state;
    capture_state_t    next_state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] pretrig;
    logic [ADDR_W-1:0] remaining;
    logic              pending;
    logic              trig_q;
    logic              strobe;
    logic              trig_event;
    logic              arm_accept;
    logic              write_en;
    logic              take_trig;

    assign trig_event = sw_trig_i | (trig_ext_en_i & trig_i & ~trig_q);

    sample_strobe_gen #(
        .DECIM_W(DECIM_W)
    ) u_strobe (
        .clk    (clk),
        .rst    (rst),
        .clear  (arm_accept),
        .decim_i(decim_i),
        .strobe (strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort overrides every other decision, including a same-cycle arm or trigger.
    always_comb begin
        next_state = state;
        arm_accept = 1'b0;
        write_en   = 1'b0;
        take_trig  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (arm_i) begin
                    arm_accept = 1'b1;
                    next_state = (pretrig_i == '0) ? ARMED : PRE;
                end
            end
            PRE: begin
                if (strobe) begin
                    write_en = 1'b1;
                    if (wr_addr == pretrig - 1'b1) begin
                        next_state = ARMED;
                    end
                end
            end
            ARMED: begin
                if (strobe) begin
                    write_en = 1'b1;
                    if (pending || trig_event) begin
                        take_trig  = 1'b1;
                        next_state = (pretrig == LAST_ADDR) ? DONE : POST;
                    end
                end
            end
            POST: begin
                if (strobe) begin
                    write_en = 1'b1;
                    if (remaining == ADDR_W'(1)) begin
                        next_state = DONE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (abort_i) begin
            next_state = IDLE;
            arm_accept = 1'b0;
            write_en   = 1'b0;
            take_trig  = 1'b0;
        end
    end

    // Status flags lag the state by one cycle on entry to DONE so that done_o
    // rises (and busy_o falls) one cycle after the final RAM write is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr      <= '0;
            pretrig      <= '0;
            remaining    <= '0;
            pending      <= 1'b0;
            trig_q       <= 1'b0;
            ram_addr_o   <= '0;
            ram_wren_o   <= 1'b0;
            ram_wdata_o  <= '0;
            busy_o       <= 1'b0;
            armed_o      <= 1'b0;
            done_o       <= 1'b0;
            trig_addr_o  <= '0;
            start_addr_o <= '0;
        end else begin
            trig_q     <= trig_i;
            ram_wren_o <= write_en;
            if (write_en) begin
                ram_addr_o  <= wr_addr;
                ram_wdata_o <= data_i;
                wr_addr     <= wr_addr + 1'b1;
            end
            if (arm_accept) begin
                wr_addr <= '0;
                pretrig <= pretrig_i;
                pending <= 1'b0;
            end
            if (take_trig) begin
                trig_addr_o  <= wr_addr;
                start_addr_o <= wr_addr - pretrig;
                remaining    <= LAST_ADDR - pretrig;
                pending      <= 1'b0;
            end else if (state == ARMED && trig_event) begin
                pending <= 1'b1;
            end
            if (state == POST && write_en) begin
                remaining <= remaining - 1'b1;
            end
            if (abort_i) begin
                pending <= 1'b0;
            end
            busy_o  <= is_busy(next_state) || (is_busy(state) && next_state == DONE);
            armed_o <= (next_state == ARMED);
            done_o  <= (state == DONE) && (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_iq_capture_sequencer.sv
// Scoreboard bench for iq_capture_sequencer (D = 16): expected RAM writes come
// from a per-acquisition arithmetic model; a negedge monitor pops and compares.
module tb_iq_capture_sequencer;
    import iq_capture_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int DECIM_W = 16;
    localparam int D       = 16;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  data_i;
    logic               arm_i;
    logic               abort_i;
    logic               sw_trig_i;
    logic               trig_i;
    logic               trig_ext_en_i;
    logic [ADDR_W-1:0]  pretrig_i;
    logic [DECIM_W-1:0] decim_i;
    logic [ADDR_W-1:0]  ram_addr_o;
    logic               ram_wren_o;
    logic [DATA_W-1:0]  ram_wdata_o;
    logic               busy_o;
    logic               armed_o;
    logic               done_o;
    logic [ADDR_W-1:0]  trig_addr_o;
    logic [ADDR_W-1:0]  start_addr_o;

    int  cyc_cnt = 0;
    int  checks  = 0;
    int  passed  = 0;
    wr_t exp_q[$];

    iq_capture_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DECIM_W(DECIM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .sw_trig_i    (sw_trig_i),
        .trig_i       (trig_i),
        .trig_ext_en_i(trig_ext_en_i),
        .pretrig_i    (pretrig_i),
        .decim_i      (decim_i),
        .ram_addr_o   (ram_addr_o),
        .ram_wren_o   (ram_wren_o),
        .ram_wdata_o  (ram_wdata_o),
        .busy_o       (busy_o),
        .armed_o      (armed_o),
        .done_o       (done_o),
        .trig_addr_o  (trig_addr_o),
        .start_addr_o (start_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc_cnt);
    endtask

    // Monitor: every presented write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ram_wren_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write (cycle %0d)",
                         ram_addr_o, ram_wdata_o, cyc_cnt);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check_output("wr_cycle", cyc_cnt, w.cyc);
                check_output("wr_addr", ram_addr_o, w.addr);
                check_output("wr_data", ram_wdata_o, w.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit arm, input int p, input int dec);
        arm_i     = arm;
        pretrig_i = ADDR_W'(p);
        decim_i   = DECIM_W'(dec);
        data_i    = DATA_W'(cyc_cnt);
        sw_trig_i = 1'b0;
        abort_i   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            step();
            apply_stimulus(1'b0, $urandom_range(0, 15), $urandom_range(0, 7));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_wren"}, ram_wren_o, 0);
        check_output({tag, "_addr"}, ram_addr_o, 0);
        check_output({tag, "_wdata"}, ram_wdata_o, 0);
        check_output({tag, "_busy"}, busy_o, 0);
        check_output({tag, "_armed"}, armed_o, 0);
        check_output({tag, "_done"}, done_o, 0);
        check_output({tag, "_trig_addr"}, trig_addr_o, 0);
        check_output({tag, "_start_addr"}, start_addr_o, 0);
    endtask

    function automatic int strobe_at(input int a, input int dec, input int k);
        return a + 1 + k * (dec + 1);
    endfunction

    // One acquisition. cut_mode: 0 run to DONE, 1 abort+arm in POST, 2 rst in POST.
    task automatic run_capture(input int p, input int dec, input int trig_off,
                               input bit use_ext, input int cut_mode);
        int a, c_as, e, k_trig, n_wr, cut, end_w, w, trig_strobe, last_strobe;
        wr_t item;
        step();
        a = cyc_cnt;
        apply_stimulus(1'b1, p, dec);
        trig_ext_en_i = use_ext;
        trig_i        = 1'b0;

        c_as        = (p == 0) ? a + 1 : strobe_at(a, dec, p - 1) + 1;
        e           = c_as + trig_off;
        k_trig      = (e - a - 1 + dec) / (dec + 1);
        n_wr        = k_trig + D - p;
        trig_strobe = strobe_at(a, dec, k_trig);
        last_strobe = strobe_at(a, dec, n_wr - 1);
        cut         = (cut_mode != 0) ? trig_strobe + 1 + int'($urandom_range(0, 3)) : last_strobe + 100;
        for (int k = 0; k < n_wr; k++) begin
            if (strobe_at(a, dec, k) < cut) begin
                item.cyc  = strobe_at(a, dec, k) + 1;
                item.addr = k % D;
                item.data = strobe_at(a, dec, k);
                exp_q.push_back(item);
            end
        end
        end_w = (cut_mode != 0) ? cut + 3 : last_strobe + 2;

        while (cyc_cnt < end_w) begin
            step();
            w = cyc_cnt;
            apply_stimulus(w < cut && w <= last_strobe && $urandom_range(0, 7) == 0,
                           $urandom_range(0, 15), $urandom_range(0, 7));
            if (use_ext) trig_i = (w >= e && w < e + 3);
            else         trig_i = 1'($urandom_range(0, 1));
            if (p > 0 && w == a + 1) sw_trig_i = 1'b1;
            if (!use_ext && w == e) sw_trig_i = 1'b1;
            if (w > trig_strobe && w < cut && $urandom_range(0, 3) == 0) sw_trig_i = 1'b1;

            if (w == a + 1) begin
                check_output("arm_busy", busy_o, 1);
                check_output("arm_done_clear", done_o, 0);
            end
            if (p > 0 && w == c_as - 1) check_output("pre_armed", armed_o, 0);
            if (w == c_as) check_output("armed_entry", armed_o, 1);

            if (cut_mode == 0) begin
                if (w == last_strobe + 1) begin
                    check_output("done_early", done_o, 0);
                    check_output("busy_last_write", busy_o, 1);
                end
                if (w == last_strobe + 2) begin
                    check_output("done", done_o, 1);
                    check_output("busy_at_done", busy_o, 0);
                    check_output("armed_at_done", armed_o, 0);
                    check_output("trig_addr", trig_addr_o, k_trig % D);
                    check_output("start_addr", start_addr_o, (k_trig - p + D) % D);
                end
            end else begin
                if (w == cut) begin
                    if (cut_mode == 1) begin
                        abort_i = 1'b1;
                        arm_i   = 1'b1;
                    end else begin
                        rst = 1'b1;
                    end
                end
                if (w == cut + 1) begin
                    if (cut_mode == 1) begin
                        check_output("abort_busy", busy_o, 0);
                        check_output("abort_done", done_o, 0);
                        check_output("abort_armed", armed_o, 0);
                        check_output("abort_wren", ram_wren_o, 0);
                    end else begin
                        check_all_zero("midrst");
                        rst = 1'b0;
                    end
                end
            end
        end
        check_output("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        sw_trig_i = 1'b0;
        trig_i    = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        data_i        = '0;
        arm_i         = 1'b0;
        abort_i       = 1'b0;
        sw_trig_i     = 1'b0;
        trig_i        = 1'b0;
        trig_ext_en_i = 1'b0;
        pretrig_i     = '0;
        decim_i       = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        run_capture(4, 0, 10, 1'b0, 0);
        run_capture(4, 0, 3, 1'b0, 0);
        run_capture(0, 2, 1, 1'b1, 0);
        run_capture(15, 0, 2, 1'b0, 0);
        run_capture(15, 1, 0, 1'b1, 0);
        run_capture(4, 0, 2, 1'b0, 1);
        idle_cycles(3);
        check_output("idle_after_abort_busy", busy_o, 0);
        check_output("idle_after_abort_done", done_o, 0);
        run_capture(6, 1, 3, 1'b0, 2);
        run_capture(3, 0, 5, 1'b0, 0);

        for (int i = 0; i < 14; i++) begin
            run_capture($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 20),
                        1'($urandom_range(0, 1)), 0);
        end

        idle_cycles(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
